// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Back end for the combinational 8-bit Booth multiplier. It accepts a job
//   of `len` signed products over a valid/ready handshake and sums them into
//   a wide signed accumulator. It then holds the result on out_valid until the
//   consumer takes it.
//
//   Optional feature macro: BOOTH_ACC_SAT_EN
//     defined   -> the accumulator saturates on signed overflow
//     undefined -> the accumulator wraps in two's complement
//     The sticky overflow flag is set in both cases.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, len            job request (honoured only in IDLE) and product count
//   in_valid/in_ready     product stream handshake, in_product signed PW bits
//   out_valid/out_ready   result handshake; out_sum (AW), out_count (LEN_W)
//   busy                  state != IDLE
//   overflow              sticky signed-overflow flag for the current job
module booth_product_accumulator #(
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PW-1:0]    in_product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [AW-1:0]    out_sum,
    output logic [LEN_W-1:0]        out_count,
    output logic                    busy,
    output logic                    overflow
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 state, state_nxt;
    logic signed [AW-1:0]   acc, acc_nxt, prod_ext, sum;
    logic [LEN_W-1:0]       cnt, cnt_inc, len_q;
    logic                   beat, last, ovf;

    // A size cast of a signed operand sign-extends it to AW bits.
    assign prod_ext = AW'(in_product);
    assign sum      = acc + prod_ext;
    assign ovf      = (acc[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc[AW-1]);
    assign cnt_inc  = LEN_W'(cnt + 1'b1);
    assign beat     = (state == ACC) && in_valid && in_ready;
    assign last     = beat && (cnt_inc == len_q);

    always_comb begin
        acc_nxt = sum;
`ifdef BOOTH_ACC_SAT_EN
        // Overflow can only occur when both operands share a sign. The sign
        // of the old acc therefore tells us which rail to clamp to.
        if (ovf)
            acc_nxt = acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)     state_nxt = (len == '0) ? DONE : ACC;
            ACC:  if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            overflow  <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            state <= state_nxt;
            // Registered ready: it is low in the first ACC cycle and drops at
            // the edge that takes the last beat.
            in_ready <= (state == ACC) && (state_nxt == ACC);
            case (state)
                IDLE: if (start) begin
                    acc       <= '0;
                    cnt       <= '0;
                    overflow  <= 1'b0;
                    len_q     <= len;
                    // A zero-length job goes straight to DONE with an empty result.
                    out_sum   <= '0;
                    out_count <= '0;
                end
                ACC: if (beat) begin
                    acc <= acc_nxt;
                    cnt <= cnt_inc;
                    if (ovf) overflow <= 1'b1;
                    // Load the result registers on the final beat so they stay
                    // stable throughout DONE.
                    if (last) begin
                        out_sum   <= acc_nxt;
                        out_count <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;
    localparam int PW = 16;
    localparam int LW = 8;
`ifdef BOOTH_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [LW-1:0] len;
    logic signed [PW-1:0] in_product;

    logic in_ready, out_valid, busy, overflow;
    logic signed [23:0] out_sum;
    logic [LW-1:0] out_count;

    logic in_ready_s, out_valid_s, busy_s, overflow_s;
    logic signed [16:0] out_sum_s;
    logic [LW-1:0] out_count_s;

    always #5 clk = ~clk;

    booth_product_accumulator #(.PW(PW), .AW(24), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .busy(busy), .overflow(overflow));

    booth_product_accumulator #(.PW(PW), .AW(17), .LEN_W(LW)) dut_s (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_product(in_product),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
        .out_count(out_count_s), .busy(busy_s), .overflow(overflow_s));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        longint sum;
        longint sum_s;
        int     cnt;
        bit     ovf;
        bit     ovf_s;
    } exp_t;

    exp_t sb[$];
    int   prods[$];

    // Reference accumulate of width w: detect overflow, then wrap or clamp.
    task automatic mdl_add(input int w, inout longint acc, inout bit ovf, input longint p);
        longint hi, lo, s;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        s  = acc + p;
        if (s > hi || s < lo) begin
            ovf = 1'b1;
            if (SAT) s = (s > hi) ? hi : lo;
            else     s = (s > hi) ? s - (hi - lo + 1) : s + (hi - lo + 1);
        end
        acc = s;
    endtask

    // Scoreboard: compare each result as the output handshake completes.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum",       longint'(out_sum),   e.sum);
                chk("count",     longint'(out_count), e.cnt);
                chk("ovf",       longint'(overflow),  e.ovf);
                chk("sum17",     longint'(out_sum_s), e.sum_s);
                chk("ovf17",     longint'(overflow_s), e.ovf_s);
                chk("valid17",   longint'(out_valid_s), 1);
            end
        end
    end

    task automatic abort_run(input string tag);
        chk(tag, 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    endtask

    // Present one product after a random gap and wait until it is taken.
    task automatic send_beat(input int p, input int gap_max);
        int t;
        repeat ($urandom_range(gap_max, 0)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid   = 1'b1;
        in_product = PW'(p);
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) abort_run("beat_timeout");
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int gap_max, input int hold);
        exp_t   e;
        longint a = 0, as = 0;
        bit     o = 0, os = 0;
        int     n;
        n = prods.size();
        foreach (prods[i]) begin
            mdl_add(24, a, o, prods[i]);
            mdl_add(17, as, os, prods[i]);
        end
        e.sum = a; e.sum_s = as; e.cnt = n; e.ovf = o; e.ovf_s = os;
        sb.push_back(e);

        out_ready = (hold == 0);
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("len0_valid", out_valid, 1);
            chk("len0_ready", in_ready, 0);
        end else begin
            @(negedge clk);
            chk("entry_ready", in_ready, 0);
            chk("entry_busy", busy, 1);
            @(posedge clk); #1;
            foreach (prods[i]) send_beat(prods[i], gap_max);
            @(negedge clk);
            chk("latency", out_valid, 1);
        end
        for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            len   = 8'd7;
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_sum", longint'(out_sum), e.sum);
        end
        if (hold > 0) out_ready = 1'b1;
        // start may still be high across the handshake edge and must be ignored.
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_product = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sum", longint'(out_sum), 0);
        chk("rst_count", longint'(out_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        prods = '{15, -28, -72};
        run_job(0, 0);
        run_job(0, 5);
        prods = {};
        run_job(0, 0);
        prods = '{32767, 32767, 32767, 32767};
        run_job(0, 0);

        // Reset in the middle of a job: nothing may be emitted.
        start = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        send_beat(1000, 3);
        send_beat(-2000, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_sum", longint'(out_sum), 0);
        chk("mid_rst_count", longint'(out_count), 0);
        @(posedge clk); #1;
        prods = '{100, -1};
        run_job(2, 0);

        for (int j = 0; j < 4; j++) begin
            prods = {};
            for (int i = 0; i < int'($urandom_range(8, 1)); i++)
                prods.push_back(int'($urandom_range(65535, 0)) - 32768);
            run_job(3, int'($urandom_range(2, 0)));
        end

        repeat (2) @(posedge clk);
        chk("sb_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
